des_ip_loader: RTL and testbench
================================

Name: des_ip_loader

Overview:
Input-side front end of the DES/TDES datapath. It gathers plaintext or ciphertext beats from a narrow valid/ready stream into a 64-bit block, applies the DES initial permutation (IP), and presents the L0/R0 halves to the round engine over a valid/ready interface. It is the inverse counterpart of the final-permutation stage that rebuilds ct[1:64] from r/l. A one-block output register lets the next block assemble while the round engine stalls.

Parameters:
IN_W, 8, input beat width in bits; legal values 8, 16, 32, 64.
BEATS, 64/IN_W, beats per block (derived localparam, not overridable).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset; deassert synchronously externally.
in_data  input  IN_W  beat data; bit IN_W-1 (MSB) is the lowest-numbered block bit of the beat.
in_vld  input  1  beat valid.
in_sof  input  1  first beat of a block; qualified by in_vld.
in_rdy  output  1  beat accepted when in_vld & in_rdy.
out_l  output  [1:32]  L0 = IP(block)[1:32].
out_r  output  [1:32]  R0 = IP(block)[33:64].
out_vld  output  1  L0/R0 valid.
out_rdy  input  1  round engine accepts when out_vld & out_rdy.
sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Block numbering is DES numbering pt[1:64]. Beat k (0-based) carries pt[k*IN_W+1 : (k+1)*IN_W], pt[k*IN_W+1] on in_data MSB.
- IP: out_l = pt 58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8. out_r = pt 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7. IP is applied combinationally on the assembly register and registered into the output register.
- Assembly FSM: IDLE (beat_cnt=0) -> FILL (0<beat_cnt<BEATS) -> FULL (all beats held, waiting for the output register). FULL is entered only when the output register is occupied and not draining.
- in_rdy = 1 in IDLE and FILL; 0 in FULL.
- On the last beat: if the output register is empty, or drains in the same cycle (out_vld & out_rdy), load L0/R0 directly. out_vld is asserted on the next cycle, giving 1-cycle latency from last-beat handshake to out_vld. Otherwise go to FULL, and transfer on the first cycle the output register frees; FULL then returns to IDLE.
- Framing: in_sof with beat_cnt != 0 drops the partial block, pulses sync_err, and restarts with that beat as beat 0. A beat without in_sof at beat_cnt == 0 is dropped (consumed, not stored) and pulses sync_err. When IN_W=64, in_sof is required on every beat.
- Output register: out_vld holds until out_rdy. out_l/out_r are stable while out_vld & !out_rdy. Back-to-back blocks sustain one block per BEATS cycles.
- Reset (any time, including mid-block): beat_cnt=0, FSM=IDLE, out_vld=0, out_l=0, out_r=0, sync_err=0, assembly register=0. in_rdy becomes 1 on the first clock after deassertion.

Optional Feature:
DES_IP_BLKCNT_EN: when defined, adds output port blk_cnt (16 bits). It counts completed output handshakes, resets to 0, wraps 0xFFFF -> 0, and is used for throughput debug. When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package des_pkg: DES_BLK_W=64, DES_HALF_W=32, the IP index table as a constant array, and the FSM state enum {IDLE, FILL, FULL}.
- One natural sub-module: des_ip_perm, purely combinational 64 -> L/R mapping, reusable by a key/IV path. The FSM, counter and registers stay in des_ip_loader.

Test Plan:
- IN_W=8, bytes 01 23 45 67 89 AB CD EF (sof on first), out_rdy=1 -> out_l=0xCC00CCFF, out_r=0xF0AAF0AA, out_vld one cycle after the 8th beat.
- Block 0x8000000000000000 -> out_l=0, out_r=0x01000000. Block of all ones -> out_l=out_r=0xFFFFFFFF.
- out_rdy=0 with two blocks streamed: first is held stable, second assembles and then in_rdy=0 (FULL). Raise out_rdy -> first accepted, second appears the next cycle, in_rdy returns to 1.
- sof mid-block after 3 beats -> sync_err pulses once, and the following 8 beats produce a correct block. A beat without sof in IDLE -> sync_err, no output.
- rst_n low after 5 beats and while out_vld=1 -> out_vld=0 and in_rdy=0 immediately; after release, a fresh block gives the correct L0/R0.
- With DES_IP_BLKCNT_EN and 65537 blocks -> blk_cnt=1.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg - shared constants and types for the DES input/IP datapath.
//   DES_BLK_W  : block width (64)
//   DES_HALF_W : half-block width (32)
//   IP_TAB     : initial permutation; entry i is the pt[] index (1-based)
//                that lands on IP output bit i+1
//   ip_state_e : block assembly FSM states
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_HALF_W = 32;

    localparam int IP_TAB [DES_BLK_W] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } ip_state_e;

endpackage

// File: rtl/des_ip_perm.sv
// des_ip_perm - combinational DES initial permutation, 64 -> L0/R0.
//   blk_i : block in DES numbering, blk_i[1] = pt[1]
//   l_o   : IP(blk)[1:32]
//   r_o   : IP(blk)[33:64]
module des_ip_perm
    import des_pkg::*;
(
    input  logic [1:DES_BLK_W]  blk_i,
    output logic [1:DES_HALF_W] l_o,
    output logic [1:DES_HALF_W] r_o
);

    logic [1:DES_BLK_W] ip;

    for (genvar i = 0; i < DES_BLK_W; i++) begin : g_ip
        assign ip[i+1] = blk_i[IP_TAB[i]];
    end

    assign l_o = ip[1:DES_HALF_W];
    assign r_o = ip[DES_HALF_W+1:DES_BLK_W];

endmodule

// File: rtl/des_ip_loader.sv
// des_ip_loader - gathers IN_W-bit beats into a 64-bit DES block, applies
// the initial permutation and holds L0/R0 for the round engine.
//   clk, rst_n          : clock, async active-low reset
//   in_data/in_vld/in_sof/in_rdy : beat stream, MSB = lowest block bit
//   out_l/out_r/out_vld/out_rdy  : L0/R0 to the round engine
//   sync_err            : one-cycle pulse on a framing error
//   blk_cnt             : completed output handshakes (only with
//                         DES_IP_BLKCNT_EN defined)
module des_ip_loader
    import des_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_vld,
    input  logic                  in_sof,
    output logic                  in_rdy,
    output logic [1:DES_HALF_W]   out_l,
    output logic [1:DES_HALF_W]   out_r,
    output logic                  out_vld,
    input  logic                  out_rdy,
`ifdef DES_IP_BLKCNT_EN
    output logic [15:0]           blk_cnt,
`endif
    output logic                  sync_err
);

    localparam int          BEATS   = DES_BLK_W / IN_W;
    localparam logic [3:0]  BEATS_C = 4'(BEATS);

    ip_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DES_BLK_W-1:0]   asm_q, asm_d;   // bit 63 holds pt[1]
    logic                   in_rdy_q;
    logic                   out_vld_q;
    logic [1:DES_HALF_W]    out_l_q, out_r_q;
    logic                   err_q, err_d;
    logic                   load;
    logic                   acc, out_free;
    logic [1:DES_HALF_W]    ip_l, ip_r;

    assign acc      = in_vld & in_rdy_q;
    assign out_free = ~out_vld_q | out_rdy;

    // IP is taken from the next-state assembly value so the last beat can
    // be loaded straight into the output register; in FULL asm_d == asm_q.
    des_ip_perm u_perm (
        .blk_i (asm_d),
        .l_o   (ip_l),
        .r_o   (ip_r)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        err_d   = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            FULL: begin
                if (out_free) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                if (acc) begin
                    if (in_sof) begin
                        // sof always restarts; a partial block is dropped
                        err_d = (cnt_q != 4'd0);
                        asm_d = DES_BLK_W'(in_data);
                        cnt_d = 4'd1;
                    end else if (cnt_q == 4'd0) begin
                        err_d = 1'b1;           // orphan beat, consumed
                    end else begin
                        asm_d = (asm_q << IN_W) | DES_BLK_W'(in_data);
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (cnt_d == BEATS_C) begin
                        cnt_d = 4'd0;
                        if (out_free) begin
                            load    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = FULL;
                        end
                    end else begin
                        state_d = (cnt_d == 4'd0) ? IDLE : FILL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            asm_q     <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            // registered ready: low in reset, up on the first clock after
            in_rdy_q <= (state_d != FULL);
            err_q    <= err_d;
            if (load) begin
                out_vld_q <= 1'b1;
                out_l_q   <= ip_l;
                out_r_q   <= ip_r;
            end else if (out_rdy) begin
                out_vld_q <= 1'b0;
            end
        end
    end

`ifdef DES_IP_BLKCNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blk_cnt_q <= 16'd0;
        else if (out_vld_q & out_rdy)
            blk_cnt_q <= blk_cnt_q + 16'd1;
    end

    assign blk_cnt = blk_cnt_q;
`endif

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_l    = out_l_q;
    assign out_r    = out_r_q;
    assign sync_err = err_q;

endmodule

// File: tb/tb_des_ip_loader.sv
module tb_des_ip_loader;

    localparam int IN_W  = 8;
    localparam int BEATS = 64 / IN_W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_vld = 1'b0;
    logic            in_sof = 1'b0;
    logic            in_rdy;
    logic [1:32]     out_l, out_r;
    logic            out_vld;
    logic            out_rdy = 1'b1;
    logic            sync_err;
`ifdef DES_IP_BLKCNT_EN
    logic [15:0]     blk_cnt;
`endif

    des_ip_loader #(.IN_W(IN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_sof   (in_sof),
        .in_rdy   (in_rdy),
        .out_l    (out_l),
        .out_r    (out_r),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
`ifdef DES_IP_BLKCNT_EN
        .blk_cnt  (blk_cnt),
`endif
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int out_cnt = 0;
    int err_cnt = 0;
    logic [63:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference IP from the closed-form column pattern of the DES table.
    function automatic logic [63:0] ip_model(input logic [63:0] b);
        logic [31:0] l, r;
        for (int i = 0; i < 32; i++) begin
            l[31-i] = b[64 - (58 + 2*(i/8) - 8*(i%8))];
            r[31-i] = b[64 - (57 + 2*(i/8) - 8*(i%8))];
        end
        return {l, r};
    endfunction

    // Scoreboard: compare every output handshake against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sync_err) err_cnt++;
            if (out_vld && out_rdy) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: got %h expected none", {out_l, out_r});
                end else begin
                    chk("block_out", {out_l, out_r}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic beat(input logic [IN_W-1:0] d, input logic sof);
        int n;
        n = 0;
        in_data = d;
        in_sof  = sof;
        in_vld  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 200) begin
                checks++;
                $display("FAIL beat_timeout: in_rdy=%b expected 1", in_rdy);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] blk);
        for (int k = 0; k < BEATS; k++)
            beat(blk[63 - k*IN_W -: IN_W], k == 0);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [63:0] blk;
        logic [63:0] exp;
    } vec_t;

    vec_t tab [6];

    initial begin
        logic [63:0] a, b, x;
        int e0, o0;

        tab[0] = '{64'h0123456789ABCDEF, 64'hCC00CCFF_F0AAF0AA};
        tab[1] = '{64'h8000000000000000, 64'h00000000_01000000};
        tab[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
        for (int i = 3; i < 6; i++) begin
            tab[i].blk = {$urandom, $urandom};
            tab[i].exp = ip_model(tab[i].blk);
        end

        // reset state
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_out_lr", {out_l, out_r}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_rdy_after_rst", in_rdy, 1);

        // table vectors, out_rdy high; out_vld one cycle after last beat
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(tab[i].exp);
            send_block(tab[i].blk);
            chk("latency_vld", out_vld, 1);
        end
        clocks(3);
        chk("tab_drained", exp_q.size(), 0);

        // stall: A held stable, B assembles then FULL
        out_rdy = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        exp_q.push_back(ip_model(a));
        send_block(a);
        exp_q.push_back(ip_model(b));
        send_block(b);
        chk("full_in_rdy", in_rdy, 0);
        chk("full_out_vld", out_vld, 1);
        chk("hold_a", {out_l, out_r}, ip_model(a));
        clocks(3);
        chk("hold_a_stable", {out_l, out_r}, ip_model(a));
        chk("full_in_rdy_stays", in_rdy, 0);
        out_rdy = 1'b1;
        clocks(1);
        chk("b_next_cycle", {out_l, out_r}, ip_model(b));
        chk("b_vld", out_vld, 1);
        chk("in_rdy_back", in_rdy, 1);
        clocks(3);
        chk("stall_drained", exp_q.size(), 0);

        // sof mid-block after 3 beats
        e0 = err_cnt;
        beat(8'hA1, 1'b1);
        beat(8'hA2, 1'b0);
        beat(8'hA3, 1'b0);
        x = 64'h133457799BBCDFF1;
        exp_q.push_back(ip_model(x));
        send_block(x);
        clocks(3);
        chk("sof_mid_err", err_cnt - e0, 1);
        chk("sof_mid_drained", exp_q.size(), 0);

        // beat without sof in IDLE
        e0 = err_cnt;
        o0 = out_cnt;
        beat(8'h55, 1'b0);
        clocks(4);
        chk("orphan_err", err_cnt - e0, 1);
        chk("orphan_no_out", out_cnt - o0, 0);

        // reset mid-block while out_vld is held
        out_rdy = 1'b0;
        send_block({$urandom, $urandom});
        for (int k = 0; k < 5; k++) beat(8'(k + 3), k == 0);
        chk("pre_rst_vld", out_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", out_vld, 0);
        chk("rst_mid_in_rdy", in_rdy, 0);
        chk("rst_mid_lr", {out_l, out_r}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("in_rdy_after_rst2", in_rdy, 1);
        exp_q.push_back(tab[0].exp);
        send_block(tab[0].blk);
        chk("post_rst_latency", out_vld, 1);

        // bounded drain of anything still expected
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) clocks(1);
        chk("final_drained", exp_q.size(), 0);
`ifdef DES_IP_BLKCNT_EN
        // counter restarted at the mid-test reset: one block since then
        chk("blk_cnt", blk_cnt, 1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
